// File: rtl/terminal_pkg.sv
// ============================================================================
// Module : terminal_pkg
// Brief  : Console page number, register offsets and bit indices.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package terminal_pkg;

  // Console page shared by the terminal input and output devices.
  localparam logic [23:0] c_base_page = 24'h000002;

  localparam logic [7:0] c_off_data   = 8'h00;
  localparam logic [7:0] c_off_status = 8'h04;
  localparam logic [7:0] c_off_ctrl   = 8'h08;

  localparam int unsigned c_stat_nonempty  = 0;
  localparam int unsigned c_stat_full      = 1;
  localparam int unsigned c_stat_overflow  = 2;
  localparam int unsigned c_stat_count_lsb = 8;
  localparam int unsigned c_stat_count_w   = 9;

  localparam int unsigned c_ctrl_flush   = 0;
  localparam int unsigned c_ctrl_clr_ovf = 1;
  localparam int unsigned c_ctrl_ie      = 2;

endpackage

`default_nettype wire

// File: rtl/terminal_input_if.sv
// ============================================================================
// Module : terminal_input_if
// Brief  : CPU load/store bus plus the character strobe from the byte source.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface terminal_input_if;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        sel;
  logic        in_valid;
  logic [7:0]  in_data;

  modport master (
    output re, we, addr, data_write, in_valid, in_data,
    input  data_read, sel
  );

  modport slave (
    input  re, we, addr, data_write, in_valid, in_data,
    output data_read, sel
  );
endinterface

`default_nettype wire

// File: rtl/terminal_fifo.sv
// ============================================================================
// Module : terminal_fifo
// Brief  : 8-bit synchronous FIFO, combinational head; flush beats push/pop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module terminal_fifo #(
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a push is taken even when full.
  assign w_pop_ok  = pop && !empty && !flush;
  assign w_push_ok = push && !flush && (!full || w_pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CW'(1);
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/terminal_input.sv
// ============================================================================
// Module : terminal_input
// Brief  : Memory-mapped console input: DATA/STATUS/CTRL over a byte FIFO.
//          Define TERMINAL_INPUT_IRQ_EN for the ie bit and irq output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module terminal_input
  import terminal_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [23:0] BASE_PAGE = c_base_page,
  localparam int         CW        = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  terminal_input_if.slave  bus
`ifdef TERMINAL_INPUT_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic          w_sel;
  logic [7:0]    w_off;
  logic          w_pop;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_clr_ovf;
  logic          w_ovf_set;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic [8:0]    w_count9;
  logic          w_full;
  logic          w_empty;
  logic          r_overflow;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_sel     = (bus.addr[31:8] == BASE_PAGE);
  assign w_off     = bus.addr[7:0];
  assign w_pop     = bus.re && w_sel && (w_off == c_off_data) && !w_empty;
  assign w_ctrl_wr = bus.we && w_sel && (w_off == c_off_ctrl);
  assign w_flush   = w_ctrl_wr && bus.data_write[c_ctrl_flush];
  assign w_clr_ovf = w_ctrl_wr && bus.data_write[c_ctrl_clr_ovf];
  // A drop happens only when the byte truly has nowhere to go.
  assign w_ovf_set = bus.in_valid && w_full && !w_pop && !w_flush;
  assign w_count9  = 9'(w_count);

  terminal_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.in_valid),
    .pop     (w_pop),
    .flush   (w_flush),
    .din     (bus.in_data),
    .dout    (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_overflow <= 1'b0;
    else if (w_ovf_set) r_overflow <= 1'b1;
    else if (w_clr_ovf) r_overflow <= 1'b0;
  end

`ifdef TERMINAL_INPUT_IRQ_EN
  logic r_ie;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_ie <= 1'b0;
    else if (w_ctrl_wr) r_ie <= bus.data_write[c_ctrl_ie];
  end

  assign irq      = r_ie && !w_empty;
  assign w_unused = ^bus.data_write[31:3];
`else
  assign w_unused = ^bus.data_write[31:2];
`endif

  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_off)
        c_off_data: begin
          if (!w_empty) w_rdata[7:0] = w_head;
        end
        c_off_status: begin
          w_rdata[c_stat_nonempty] = !w_empty;
          w_rdata[c_stat_full]     = w_full;
          w_rdata[c_stat_overflow] = r_overflow;
          w_rdata[c_stat_count_lsb +: c_stat_count_w] = w_count9;
        end
        c_off_ctrl: begin
`ifdef TERMINAL_INPUT_IRQ_EN
          w_rdata[c_ctrl_ie] = r_ie;
`endif
        end
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.data_read = w_rdata;
  assign bus.sel       = w_sel;

endmodule

`default_nettype wire
